// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store bus master with a single outstanding access.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating their offset.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_req_M,
    input  logic                  i_mem_write_M,
    input  logic [2:0]            i_funct3_MEM,
    input  logic [DATA_WIDTH-1:0] i_data_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    output logic                  o_stall_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    output logic                  o_load_valid,
    output logic                  o_misaligned,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [DATA_WIDTH-1:0] o_bus_addr,
    output logic [3:0]            o_bus_be,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_gnt,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0] state, state_nx;
    logic [2:0] funct3_q;
    logic [1:0] off, off_q;
    logic mis, accept;
    logic [3:0] be;
    logic [DATA_WIDTH-1:0] wdata, load_ext;
    logic [7:0] lane_b;
    logic [15:0] lane_h;

    assign mis = (i_funct3_MEM[1:0] == 2'b01 && i_data_addr_M[0]) ||
                 (i_funct3_MEM == 3'b010 && i_data_addr_M[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    // A trapped access never leaves IDLE, so it must not stall the pipeline.
    assign accept       = rst && state == IDLE && i_mem_req_M && !mis;
    assign o_misaligned = rst && state == IDLE && i_mem_req_M && mis;
`else
    assign accept       = rst && state == IDLE && i_mem_req_M;
    assign o_misaligned = 1'b0;
`endif
    assign o_stall_M    = accept || state == REQ || state == WAIT;
    assign o_bus_req    = state == REQ;
    assign o_load_valid = state == DONE && !o_bus_we;

    always_comb begin
        off = i_funct3_MEM[1:0] == 2'b00 ? i_data_addr_M[1:0] :
              i_funct3_MEM[1:0] == 2'b01 ? {i_data_addr_M[1], 1'b0} : 2'b00;
        be = i_funct3_MEM[1:0] == 2'b00 ? 4'b0001 << off :
             i_funct3_MEM[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata = i_funct3_MEM[1:0] == 2'b00 ? {4{i_write_data_M[7:0]}} :
                i_funct3_MEM[1:0] == 2'b01 ? {2{i_write_data_M[15:0]}} : i_write_data_M;
        lane_b = 8'(i_bus_rdata >> {off_q, 3'b000});
        lane_h = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        load_ext = funct3_q[1:0] == 2'b00 ? {{(DATA_WIDTH-8){lane_b[7] & ~funct3_q[2]}}, lane_b} :
                   funct3_q[1:0] == 2'b01 ? {{(DATA_WIDTH-16){lane_h[15] & ~funct3_q[2]}}, lane_h} :
                   i_bus_rdata;
        state_nx = state == IDLE ? (accept ? REQ : IDLE) :
                   state == REQ  ? (i_bus_gnt ? (o_bus_we ? DONE : WAIT) : REQ) :
                   state == WAIT ? (i_bus_rvalid ? DONE : WAIT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            funct3_q      <= '0;
            off_q         <= '0;
            o_bus_we      <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_be      <= '0;
            o_bus_wdata   <= '0;
            o_read_data_M <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                funct3_q    <= i_funct3_MEM;
                off_q       <= off;
                o_bus_we    <= i_mem_write_M;
                o_bus_addr  <= {i_data_addr_M[DATA_WIDTH-1:2], 2'b00};
                o_bus_be    <= be;
                o_bus_wdata <= wdata;
            end
            if (state == WAIT && i_bus_rvalid) o_read_data_M <= load_ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, reset corner sequences and randomized accesses
// checked against a size/offset arithmetic reference model.
module tb_load_store_unit;
    logic clk = 1'b0, rst = 1'b0;
    logic mem_req = 1'b0, mem_write = 1'b0, gnt = 1'b0, rvalid = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] addr = '0, wdata_in = '0, rdata = '0;
    logic stall, load_valid, misaligned, bus_req, bus_we;
    logic [31:0] read_data, bus_addr, bus_wdata;
    logic [3:0] bus_be;
    int total = 0, bad = 0;
    logic [31:0] last_rd = '0;
    int r_stall, r_lv, r_req, r_mis, r_unstable;
    logic [3:0] r_be;
    logic [31:0] r_addr, r_wd, r_rd;
    logic r_we;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd_bus;
        int          gw, rw;
        logic        noise;
        logic [3:0]  be;
        logic [31:0] ewd, erd;
        int          stall;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .i_mem_req_M(mem_req), .i_mem_write_M(mem_write), .i_funct3_MEM(funct3),
        .i_data_addr_M(addr), .i_write_data_M(wdata_in),
        .o_stall_M(stall), .o_read_data_M(read_data), .o_load_valid(load_valid),
        .o_misaligned(misaligned), .o_bus_req(bus_req), .o_bus_we(bus_we),
        .o_bus_addr(bus_addr), .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
        .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Access width from funct3[1:0], offset aligned down to the width, lane picked arithmetically.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                                  output logic [3:0] ebe, output logic [31:0] ewd, erd,
                                  output logic emis);
        int size, off;
        longint mask, val;
        size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        off = int'(a % 4);
        emis = (size == 2 && off % 2 != 0) || (f3 == 3'b010 && off != 0);
        off -= off % size;
        ebe = 4'(((1 << size) - 1) << off);
        mask = (64'd1 << (8 * size)) - 1;
        ewd = size == 4 ? wd : size == 2 ? wd[15:0] * 32'h0001_0001 : wd[7:0] * 32'h0101_0101;
        val = (longint'(rdat) >> (8 * off)) & mask;
        if (size < 4 && !f3[2] && val >= (mask + 1) / 2) val -= mask + 1;
        erd = 32'(val);
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the access completes.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rd_bus,
                           input int gw, input int rw, input logic noise);
        int reqs = 0, waits = 0;
        logic granted = 1'b0, done = 1'b0;
        r_stall = 0; r_lv = 0; r_req = 0; r_mis = 0; r_unstable = 0;
        r_be = '0; r_addr = '0; r_wd = '0; r_rd = '0; r_we = 1'b0;
        mem_req = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata_in = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) r_stall++;
            if (load_valid) begin r_lv++; r_rd = read_data; end
            if (misaligned) r_mis++;
            gnt = 1'b0; rvalid = 1'b0; rdata = $urandom;
            if (bus_req) begin
                if (r_req > 0 && (bus_be != r_be || bus_addr != r_addr || bus_wdata != r_wd)) r_unstable++;
                r_req++; r_be = bus_be; r_addr = bus_addr; r_wd = bus_wdata; r_we = bus_we;
                if (reqs == gw) begin gnt = 1'b1; granted = 1'b1; end
                reqs++;
                if (noise) begin rvalid = 1'b1; rdata = ~rd_bus; end
            end else if (granted && !we && stall) begin
                if (waits == rw) begin rvalid = 1'b1; rdata = rd_bus; end
                waits++;
            end
            if (!stall) done = 1'b1;
            @(posedge clk); #1;
        end
        mem_req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: access f3=%b addr=0x%h never completed", f3, a);
        end
    endtask

    task automatic verify(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rd_bus,
                          input int gw, input int rw, input logic noise);
        logic [3:0] ebe;
        logic [31:0] ewd, erd;
        logic emis, trap;
        model(f3, a, wd, rd_bus, ebe, ewd, erd, emis);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = emis;
`else
        trap = 1'b0;
`endif
        run_txn(we, f3, a, wd, rd_bus, gw, rw, noise);
        chk("misaligned_pulses", r_mis, 32'(trap));
        if (trap) begin
            chk("trap_bus_req", r_req, 0);
            chk("trap_stall", r_stall, 0);
        end else begin
            chk("be", r_be, ebe);
            chk("bus_addr", r_addr, {a[31:2], 2'b00});
            chk("bus_we", r_we, we);
            chk("req_cycles", r_req, gw + 1);
            chk("bus_unstable", r_unstable, 0);
            chk("stall_cycles", r_stall, 2 + gw + (we ? 0 : rw + 1));
            chk("load_valid_cycles", r_lv, we ? 0 : 1);
            if (we) chk("wdata", r_wd, ewd);
            else begin
                chk("read_data", r_rd, erd);
                last_rd = erd;
            end
        end
        chk("read_data_hold", read_data, last_rd);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        3};
        vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0,        2};
        vecs[2]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'h12F45678, 0, 0, 1'b0, 4'h4, 32'h0,        32'hFFFFFFF4, 3};
        vecs[3]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h12F45678, 0, 0, 1'b0, 4'h4, 32'h0,        32'h000000F4, 3};
        vecs[4]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        0, 0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0,        2};
        vecs[5]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 0, 0, 1'b0, 4'hC, 32'h0,        32'h00008001, 3};
        vecs[6]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h80017FFF, 0, 0, 1'b0, 4'h3, 32'h0,        32'h00007FFF, 3};
        vecs[7]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h89ABCDEF, 2, 3, 1'b0, 4'hF, 32'h0,        32'h89ABCDEF, 8};
        vecs[8]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00008000, 0, 0, 1'b0, 4'h2, 32'h0,        32'hFFFFFF80, 3};
        vecs[9]  = '{1'b0, 3'b010, 32'h10C, 32'h0,        32'h00000055, 1, 1, 1'b1, 4'hF, 32'h0,        32'h00000055, 5};
        vecs[10] = '{1'b1, 3'b111, 32'h108, 32'h0BADF00D, 32'h0,        0, 0, 1'b0, 4'hF, 32'h0BADF00D, 32'h0,        2};
        #3;
        chk("reset_ctrl_outputs", {23'd0, stall, load_valid, misaligned, bus_req, bus_we, bus_be}, 32'h0);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk("reset_bus_wdata", bus_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd_bus,
                    vecs[i].gw, vecs[i].rw, vecs[i].noise);
            chk($sformatf("vec%0d_be", i), r_be, vecs[i].be);
            chk($sformatf("vec%0d_bus_addr", i), r_addr, {vecs[i].a[31:2], 2'b00});
            chk($sformatf("vec%0d_bus_we", i), r_we, vecs[i].we);
            chk($sformatf("vec%0d_stall", i), r_stall, vecs[i].stall);
            chk($sformatf("vec%0d_load_valid", i), r_lv, vecs[i].we ? 0 : 1);
            if (vecs[i].we) chk($sformatf("vec%0d_wdata", i), r_wd, vecs[i].ewd);
            else begin
                chk($sformatf("vec%0d_read_data", i), r_rd, vecs[i].erd);
                last_rd = vecs[i].erd;
            end
            chk($sformatf("vec%0d_hold", i), read_data, last_rd);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        run_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h00008001, 0, 0, 1'b0);
        chk("lh101_misaligned", r_mis, 1);
        chk("lh101_no_bus_req", r_req, 0);
        chk("lh101_no_stall", r_stall, 0);
        chk("lh101_hold", read_data, last_rd);
`else
        run_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h00008001, 0, 0, 1'b0);
        chk("lh101_misaligned", r_mis, 0);
        chk("lh101_be", r_be, 4'h3);
        chk("lh101_read_data", r_rd, 32'hFFFF8001);
        last_rd = 32'hFFFF8001;
`endif
        // Reset in REQ drops the bus request with no clock edge.
        mem_req = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        chk("req_before_reset", bus_req, 1);
        rst = 1'b0; mem_req = 1'b0; #1;
        chk("reset_in_req_bus_req", bus_req, 0);
        chk("reset_in_req_stall", stall, 0);
        @(posedge clk); #1 rst = 1'b1;
        // Reset in WAIT, then a stray rvalid must be ignored.
        mem_req = 1'b1; funct3 = 3'b000; addr = 32'h201;
        @(posedge clk); #1 gnt = 1'b1;
        @(posedge clk); #1 gnt = 1'b0;
        chk("wait_stall", stall, 1);
        chk("wait_no_bus_req", bus_req, 0);
        rst = 1'b0; mem_req = 1'b0; #1;
        chk("reset_in_wait_stall", stall, 0);
        chk("reset_in_wait_bus_req", bus_req, 0);
        chk("reset_in_wait_read_data", read_data, 0);
        @(negedge clk);
        rst = 1'b1; rvalid = 1'b1; rdata = 32'h33;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) rvalid = 1'b0;
            chk("stray_rvalid_load_valid", load_valid, 0);
            chk("stray_rvalid_stall", stall, 0);
            chk("stray_rvalid_read_data", read_data, 0);
        end
        rvalid = 1'b0;
        last_rd = '0;
        for (int n = 0; n < 300; n++) begin
            logic we;
            logic [2:0] f3;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            verify(we, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the data and address width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 i_mem_req_M  in  1  MEM-stage instruction is a load/store.
REQ-005 i_mem_write_M  in  1  1=store, 0=load.
REQ-006 i_funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 i_data_addr_M  in  32  byte address.
REQ-008 i_write_data_M  in  32  store data, right-aligned.
REQ-009 o_stall_M  out  1  holds IF..MEM while an access is in flight.
REQ-010 o_read_data_M  out  32  extended load result.
REQ-011 o_load_valid  out  1  one-cycle pulse; o_read_data_M valid.
REQ-012 o_misaligned  out  1  one-cycle misaligned-access flag.
REQ-013 o_bus_req / o_bus_we  out  1 / 1  bus request / write.
REQ-014 o_bus_addr  out  32  word-aligned address (bits[1:0]=00).
REQ-015 o_bus_be  out  4  byte enables.
REQ-016 o_bus_wdata  out  32  lane-replicated store data.
REQ-017 i_bus_gnt / i_bus_rvalid  in  1 / 1  request accepted / read data valid.
REQ-018 i_bus_rdata  in  32  read data.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-020 IDLE: an aligned i_mem_req_M SHALL latch address, byte enables, write data, funct3, offset and we, assert o_stall_M combinationally in that cycle, and move to REQ.
REQ-021 REQ: o_bus_req=1 and o_stall_M=1, bus outputs stable until i_bus_gnt; on gnt a store moves to DONE and a load moves to WAIT.
REQ-022 WAIT: o_stall_M=1; on i_bus_rvalid, capture the extended data into o_read_data_M and move to DONE.
REQ-023 DONE: o_stall_M=0; o_load_valid=1 for loads only; next state IDLE.
REQ-024 i_bus_rvalid outside WAIT SHALL be ignored; gnt and rvalid are never consumed in the same cycle.
REQ-025 Byte enables: B 0001<<addr[1:0]; H 0011<<{addr[1],0}; W/reserved funct3 (011,110,111) 1111.
REQ-026 Write data: B replicated to 4 lanes; H replicated to 2 halves; W unchanged.
REQ-027 Load data: select the lane by the latched offset; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-028 o_read_data_M SHALL hold its last value between loads.
REQ-029 Minimum latency: store 3 cycles, load 4 cycles, counted from the IDLE accept to the end of DONE.
REQ-030 Misaligned access is H with addr[0]=1, or W with addr[1:0]!=00.

Reset
REQ-031 Asserting rst SHALL force IDLE at any time, including mid-transfer, and drop o_bus_req in the same cycle without waiting for a clock.
REQ-032 Reset values: all outputs 0; o_read_data_M 0.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN.
REQ-034 Defined: a misaligned request in IDLE SHALL issue no bus access, pulse o_misaligned for 1 cycle, keep o_stall_M=0, and leave o_read_data_M unchanged.
REQ-035 Undefined: o_misaligned SHALL be tied 0, the address offset SHALL be truncated to natural alignment (H clears bit0, W clears bits[1:0]), and the access proceeds normally.

Verification
REQ-036 SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> o_bus_be=1111, wdata 0xDEADBEEF, stall for 3 cycles, returns to IDLE.
REQ-037 SB addr 0x103, data 0x000000A5 -> be=1000, wdata 0xA5A5A5A5.
REQ-038 LB addr 0x102, rdata 0x12F45678 -> o_read_data_M 0xFFFFFFF4, o_load_valid 1 cycle; LBU same case -> 0x000000F4.
REQ-039 LH addr 0x101: with macro -> o_misaligned pulse, no o_bus_req; without macro -> offset truncated to 0, be=0011, rdata 0x0000_8001 yields 0xFFFF8001.
REQ-040 rst low while in WAIT -> o_bus_req, o_stall_M and FSM cleared immediately; a later rvalid is ignored and o_load_valid stays 0.
REQ-041 rvalid asserted in REQ, then gnt, then rvalid=0x55 -> only 0x55 is captured.
